// File: rtl/reg_universal_n.sv
// reg_universal_n: WIDTH-bit universal register cell.
// One register that can load, shift or rotate with serial in/out, and count
// up or down with wrap-around and a single-cycle terminal-count pulse.
// Edge priority: clr > en=0 > op. rst is asynchronous and active-low.
// There are no handshakes: every operation completes in one clock.
module reg_universal_n #(
  parameter int               WIDTH   = 12,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic             sin,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             tc,
  output logic             zero
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  logic [WIDTH-1:0] out_nxt;
  logic             sout_nxt;
  logic             tc_nxt;

  // Next-state decode; tc defaults low so it only rises on a wrap cycle.
  always_comb begin
    out_nxt  = out;
    sout_nxt = sout;
    tc_nxt   = 1'b0;
    if (clr) begin
      out_nxt  = ALL_ZERO;
      sout_nxt = 1'b0;
    end else if (en) begin
      case (op)
        OP_HOLD: out_nxt = out;
        OP_LOAD: out_nxt = in;
        OP_SHL: begin
          out_nxt  = {out[WIDTH-2:0], sin};
          sout_nxt = out[WIDTH-1];
        end
        OP_SHR: begin
          out_nxt  = {sin, out[WIDTH-1:1]};
          sout_nxt = out[0];
        end
        OP_ROL: begin
          out_nxt  = {out[WIDTH-2:0], out[WIDTH-1]};
          sout_nxt = out[WIDTH-1];
        end
        OP_ROR: begin
          out_nxt  = {out[0], out[WIDTH-1:1]};
          sout_nxt = out[0];
        end
        OP_INC: begin
          out_nxt = out + ONE;
          tc_nxt  = (out == ALL_ONES);
        end
        OP_DEC: begin
          out_nxt = out - ONE;
          tc_nxt  = (out == ALL_ZERO);
        end
        default: out_nxt = out;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out  <= RST_VAL;
      sout <= 1'b0;
      tc   <= 1'b0;
    end else begin
      out  <= out_nxt;
      sout <= sout_nxt;
      tc   <= tc_nxt;
    end
  end

  // Zero flag is purely combinational from the register contents.
  assign zero = (out == ALL_ZERO);

endmodule

// File: tb/tb_reg_universal_n.sv
// Directed testbench for reg_universal_n at WIDTH=12 (RST_VAL=0x0A5),
// WIDTH=4 and WIDTH=32. Inputs change 1 ns after a rising edge and outputs
// are checked at that same point, away from the active edge.
module tb_reg_universal_n;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
  localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, INC = 3'b110, DEC = 3'b111;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic        clr12, en12, sin12, sout12, tc12, zero12;
  logic [2:0]  op12;
  logic [11:0] in12, out12;

  logic        clr4, en4, sin4, sout4, tc4, zero4;
  logic [2:0]  op4;
  logic [3:0]  in4, out4;

  logic        clr32, en32, sin32, sout32, tc32, zero32;
  logic [2:0]  op32;
  logic [31:0] in32, out32;

  reg_universal_n #(.WIDTH(12), .RST_VAL(12'h0A5)) dut12 (
    .clk(clk), .rst(rst), .clr(clr12), .en(en12), .op(op12), .in(in12),
    .sin(sin12), .out(out12), .sout(sout12), .tc(tc12), .zero(zero12));

  reg_universal_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr4), .en(en4), .op(op4), .in(in4),
    .sin(sin4), .out(out4), .sout(sout4), .tc(tc4), .zero(zero4));

  reg_universal_n #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .clr(clr32), .en(en32), .op(op32), .in(in32),
    .sin(sin32), .out(out32), .sout(sout32), .tc(tc32), .zero(zero32));

  // ---------------- driver tasks ----------------
  task automatic drv12(input logic c, input logic e, input logic [2:0] o,
                       input logic [11:0] d, input logic s);
    clr12 = c; en12 = e; op12 = o; in12 = d; sin12 = s;
    @(posedge clk); #1;
  endtask

  task automatic drv4(input logic c, input logic e, input logic [2:0] o,
                      input logic [3:0] d, input logic s);
    clr4 = c; en4 = e; op4 = o; in4 = d; sin4 = s;
    @(posedge clk); #1;
  endtask

  task automatic drv32(input logic c, input logic e, input logic [2:0] o,
                       input logic [31:0] d, input logic s);
    clr32 = c; en32 = e; op32 = o; in32 = d; sin32 = s;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; #1 rst = 1'b0; #1;
    n_total++; if (out12 !== 12'h0A5) $display("FAIL reset_out12 got=%h exp=%h", out12, 12'h0A5); else n_pass++;
    n_total++; if (sout12 !== 1'b0) $display("FAIL reset_sout12 got=%b exp=0", sout12); else n_pass++;
    n_total++; if (tc12 !== 1'b0) $display("FAIL reset_tc12 got=%b exp=0", tc12); else n_pass++;
    n_total++; if (zero12 !== 1'b0) $display("FAIL reset_zero12 got=%b exp=0", zero12); else n_pass++;
    n_total++; if (out4 !== 4'h0 || zero4 !== 1'b1) $display("FAIL reset_w4 out=%h zero=%b exp=0/1", out4, zero4); else n_pass++;
    n_total++; if (out32 !== 32'h0) $display("FAIL reset_out32 got=%h exp=0", out32); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_inc_wrap;
    drv12(0, 1, LOAD, 12'hFFE, 0);
    n_total++; if (out12 !== 12'hFFE || tc12 !== 1'b0) $display("FAIL inc_load got=%h/%b exp=ffe/0", out12, tc12); else n_pass++;
    drv12(0, 1, INC, 12'h000, 0);
    n_total++; if (out12 !== 12'hFFF || tc12 !== 1'b0) $display("FAIL inc_1 got=%h/%b exp=fff/0", out12, tc12); else n_pass++;
    drv12(0, 1, INC, 12'h000, 0);
    n_total++; if (out12 !== 12'h000 || tc12 !== 1'b1) $display("FAIL inc_wrap got=%h/%b exp=000/1", out12, tc12); else n_pass++;
    n_total++; if (zero12 !== 1'b1) $display("FAIL inc_wrap_zero got=%b exp=1", zero12); else n_pass++;
    drv12(0, 1, INC, 12'h000, 0);
    n_total++; if (out12 !== 12'h001 || tc12 !== 1'b0) $display("FAIL inc_3 got=%h/%b exp=001/0", out12, tc12); else n_pass++;
  endtask

  task automatic test_async_reset;
    // Put sout=1 and tc=1 in place so the reset has something to clear.
    drv12(0, 1, LOAD, 12'hFFF, 0);
    drv12(0, 1, SHL, 12'h000, 0);
    n_total++; if (out12 !== 12'hFFE || sout12 !== 1'b1) $display("FAIL ar_shl got=%h/%b exp=ffe/1", out12, sout12); else n_pass++;
    drv12(0, 1, INC, 12'h000, 0);
    drv12(0, 1, INC, 12'h000, 0);
    n_total++; if (out12 !== 12'h000 || tc12 !== 1'b1) $display("FAIL ar_wrap got=%h/%b exp=000/1", out12, tc12); else n_pass++;
    #2 rst = 1'b0; #1;
    n_total++; if (out12 !== 12'h0A5 || sout12 !== 1'b0 || tc12 !== 1'b0)
      $display("FAIL ar_midcycle got=%h/%b/%b exp=0a5/0/0", out12, sout12, tc12); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out12 !== 12'h0A5) $display("FAIL ar_held got=%h exp=0a5", out12); else n_pass++;
    rst = 1'b1;
    drv12(0, 1, INC, 12'h000, 0);
    n_total++; if (out12 !== 12'h0A6 || tc12 !== 1'b0) $display("FAIL ar_first_edge got=%h/%b exp=0a6/0", out12, tc12); else n_pass++;
  endtask

  task automatic test_shift;
    drv12(0, 1, LOAD, 12'h801, 0);
    drv12(0, 1, SHL, 12'h000, 0);
    n_total++; if (out12 !== 12'h002 || sout12 !== 1'b1) $display("FAIL shl got=%h/%b exp=002/1", out12, sout12); else n_pass++;
    drv12(0, 1, SHR, 12'h000, 1);
    n_total++; if (out12 !== 12'h801 || sout12 !== 1'b0) $display("FAIL shr got=%h/%b exp=801/0", out12, sout12); else n_pass++;
  endtask

  task automatic test_rotate;
    drv12(0, 1, LOAD, 12'h001, 0);
    drv12(0, 1, ROR, 12'h000, 0);
    n_total++; if (out12 !== 12'h800 || sout12 !== 1'b1) $display("FAIL ror got=%h/%b exp=800/1", out12, sout12); else n_pass++;
    drv12(0, 1, ROL, 12'h000, 0);
    n_total++; if (out12 !== 12'h001 || sout12 !== 1'b1) $display("FAIL rol got=%h/%b exp=001/1", out12, sout12); else n_pass++;
  endtask

  task automatic test_enable_dec;
    drv12(0, 1, LOAD, 12'h000, 0);
    n_total++; if (sout12 !== 1'b1) $display("FAIL sout_hold_load got=%b exp=1", sout12); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      drv12(0, 0, INC, 12'h000, 0);
      n_total++; if (out12 !== 12'h000 || zero12 !== 1'b1 || tc12 !== 1'b0)
        $display("FAIL en0_hold_%0d got=%h/%b/%b exp=000/1/0", i, out12, zero12, tc12); else n_pass++;
    end
    drv12(0, 1, DEC, 12'h000, 0);
    n_total++; if (out12 !== 12'hFFF || tc12 !== 1'b1 || zero12 !== 1'b0)
      $display("FAIL dec_wrap got=%h/%b/%b exp=fff/1/0", out12, tc12, zero12); else n_pass++;
    drv12(0, 0, DEC, 12'h000, 0);
    n_total++; if (out12 !== 12'hFFF || tc12 !== 1'b0) $display("FAIL tc_no_stretch got=%h/%b exp=fff/0", out12, tc12); else n_pass++;
    drv12(0, 1, DEC, 12'h000, 0);
    n_total++; if (out12 !== 12'hFFE || tc12 !== 1'b0) $display("FAIL dec_plain got=%h/%b exp=ffe/0", out12, tc12); else n_pass++;
  endtask

  task automatic test_clear;
    // sout is still 1 from the rotate test, so clr must visibly drop it.
    drv12(1, 1, LOAD, 12'h123, 1);
    n_total++; if (out12 !== 12'h000 || sout12 !== 1'b0 || tc12 !== 1'b0)
      $display("FAIL clr_over_load got=%h/%b/%b exp=000/0/0", out12, sout12, tc12); else n_pass++;
    drv12(0, 1, LOAD, 12'h456, 0);
    drv12(1, 0, HOLD, 12'h000, 0);
    n_total++; if (out12 !== 12'h000) $display("FAIL clr_with_en0 got=%h exp=000", out12); else n_pass++;
  endtask

  task automatic test_width4;
    drv4(0, 1, LOAD, 4'hF, 0);
    drv4(0, 1, INC, 4'h0, 0);
    n_total++; if (out4 !== 4'h0 || tc4 !== 1'b1) $display("FAIL w4_inc_wrap got=%h/%b exp=0/1", out4, tc4); else n_pass++;
    drv4(0, 1, DEC, 4'h0, 0);
    n_total++; if (out4 !== 4'hF || tc4 !== 1'b1) $display("FAIL w4_dec_wrap got=%h/%b exp=f/1", out4, tc4); else n_pass++;
    drv4(0, 1, LOAD, 4'h9, 0);
    drv4(0, 1, SHL, 4'h0, 0);
    n_total++; if (out4 !== 4'h2 || sout4 !== 1'b1) $display("FAIL w4_shl got=%h/%b exp=2/1", out4, sout4); else n_pass++;
    drv4(0, 1, ROR, 4'h0, 0);
    n_total++; if (out4 !== 4'h1 || sout4 !== 1'b0) $display("FAIL w4_ror got=%h/%b exp=1/0", out4, sout4); else n_pass++;
    drv4(0, 1, ROR, 4'h0, 0);
    n_total++; if (out4 !== 4'h8 || sout4 !== 1'b1) $display("FAIL w4_ror2 got=%h/%b exp=8/1", out4, sout4); else n_pass++;
    drv4(1, 1, LOAD, 4'h3, 0);
    n_total++; if (out4 !== 4'h0 || sout4 !== 1'b0 || zero4 !== 1'b1)
      $display("FAIL w4_clr got=%h/%b/%b exp=0/0/1", out4, sout4, zero4); else n_pass++;
  endtask

  task automatic test_width32;
    drv32(0, 1, LOAD, 32'hFFFF_FFFF, 0);
    drv32(0, 1, INC, 32'h0, 0);
    n_total++; if (out32 !== 32'h0 || tc32 !== 1'b1) $display("FAIL w32_inc_wrap got=%h/%b exp=0/1", out32, tc32); else n_pass++;
    drv32(0, 1, DEC, 32'h0, 0);
    n_total++; if (out32 !== 32'hFFFF_FFFF || tc32 !== 1'b1) $display("FAIL w32_dec_wrap got=%h/%b exp=ffffffff/1", out32, tc32); else n_pass++;
    drv32(0, 1, LOAD, 32'h8000_0001, 0);
    drv32(0, 1, SHR, 32'h0, 1);
    n_total++; if (out32 !== 32'hC000_0000 || sout32 !== 1'b1) $display("FAIL w32_shr got=%h/%b exp=c0000000/1", out32, sout32); else n_pass++;
    drv32(0, 1, LOAD, 32'h8000_0001, 0);
    drv32(0, 1, ROL, 32'h0, 0);
    n_total++; if (out32 !== 32'h0000_0003 || sout32 !== 1'b1) $display("FAIL w32_rol got=%h/%b exp=00000003/1", out32, sout32); else n_pass++;
    drv32(1, 1, LOAD, 32'h1234_5678, 1);
    n_total++; if (out32 !== 32'h0 || sout32 !== 1'b0 || tc32 !== 1'b0)
      $display("FAIL w32_clr got=%h/%b/%b exp=0/0/0", out32, sout32, tc32); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clr12 = 0; en12 = 0; op12 = HOLD; in12 = '0; sin12 = 0;
    clr4  = 0; en4  = 0; op4  = HOLD; in4  = '0; sin4  = 0;
    clr32 = 0; en32 = 0; op32 = HOLD; in32 = '0; sin32 = 0;
    test_reset();
    test_inc_wrap();
    test_async_reset();
    test_shift();
    test_rotate();
    test_enable_dec();
    test_clear();
    test_width4();
    test_width32();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
